// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns the architectural PC and fetches one instruction
// at a time over a req/gnt/rvalid handshake, then waits for execute to retire it.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [7:0]  TIMEOUT  = 8'd255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        retire,
   input  logic [31:0] next_pc,
   output logic        fetch_err
);

   // Handshake: imem_req/imem_addr hold until imem_gnt is seen in REQ; exactly one
   // request is outstanding and its data is accepted only via imem_rvalid in WAIT.
   // instr/pc are consumable while instr_valid=1 and retire is honoured only then.

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_VALID = 2'd2,
      S_ERR   = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [7:0]  cnt_q, cnt_d;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_REQ;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         cnt_q   <= 8'd0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_REQ: begin
            if (imem_gnt) begin
               cnt_d   = 8'd0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // rvalid takes priority over a timeout expiring in the same cycle
            if (imem_rvalid) begin
               instr_d = imem_rdata;
               state_d = S_VALID;
            end else if (cnt_q == TIMEOUT) begin
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_VALID: begin
            if (retire) begin
               pc_d    = next_pc;
               state_d = (next_pc[1:0] != 2'b00) ? S_ERR : S_REQ;
            end
         end
         S_ERR: begin
            state_d = S_ERR;
         end
         default: begin
            state_d = S_ERR;
         end
      endcase
   end

   // Moore outputs
   always_comb begin
      imem_req    = (state_q == S_REQ);
      instr_valid = (state_q == S_VALID);
      fetch_err   = (state_q == S_ERR);
      imem_addr   = pc_q;
      pc          = pc_q;
      instr       = instr_q;
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed, table-driven bench for ifetch_unit: one record per clock cycle with
// the inputs to apply and the outputs expected in that cycle.
module tb_ifetch_unit;

   localparam logic [31:0] A0  = 32'h8000_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        instr_valid;
   logic        retire;
   logic [31:0] next_pc;
   logic        fetch_err;

   typedef struct {
      logic        rst;
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic        ret;
      logic [31:0] npc;
      logic        e_req;
      logic [31:0] e_pc;
      logic        e_iv;
      logic        ci;
      logic [31:0] e_instr;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];
   int   checks;
   int   passes;

   ifetch_unit #(
      .RESET_PC (32'h8000_0000),
      .TIMEOUT  (8'd4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .pc          (pc),
      .instr       (instr),
      .instr_valid (instr_valid),
      .retire      (retire),
      .next_pc     (next_pc),
      .fetch_err   (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic r, input logic g, input logic rv, input logic [31:0] rd,
                      input logic rt, input logic [31:0] np, input logic e_req,
                      input logic [31:0] e_pc, input logic e_iv, input logic ci,
                      input logic [31:0] e_instr, input logic e_err);
      vec_t v;
      v.rst = r; v.gnt = g; v.rv = rv; v.rdata = rd; v.ret = rt; v.npc = np;
      v.e_req = e_req; v.e_pc = e_pc; v.e_iv = e_iv; v.ci = ci;
      v.e_instr = e_instr; v.e_err = e_err;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int cyc, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
   endtask

   task automatic drive_idle();
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      retire = 1'b0; next_pc = 32'h0;
   endtask

   initial begin
      int n;
      checks = 0;
      passes = 0;
      rst = 1'b1;
      drive_idle();

      // Reset held for three cycles, then boot fetch with zero-wait memory
      add(1,0,0,0,0,0,                     1, A0, 0, 1, NOP, 0);
      add(1,0,0,0,0,0,                     1, A0, 0, 1, NOP, 0);
      add(0,1,0,0,0,0,                     1, A0, 0, 1, NOP, 0);
      add(0,0,1,32'h0010_0093,0,0,         0, A0, 0, 0, 0, 0);
      add(0,0,0,0,1,32'h8000_0004,         0, A0, 1, 1, 32'h0010_0093, 0);
      // Sequential then branch
      add(0,1,0,0,0,0,                     1, 32'h8000_0004, 0, 0, 0, 0);
      add(0,0,1,32'h0000_0113,0,0,         0, 32'h8000_0004, 0, 0, 0, 0);
      add(0,0,0,0,1,32'h8000_0100,         0, 32'h8000_0004, 1, 1, 32'h0000_0113, 0);
      add(0,1,0,0,0,0,                     1, 32'h8000_0100, 0, 0, 0, 0);
      add(0,0,1,32'h0020_8193,0,0,         0, 32'h8000_0100, 0, 0, 0, 0);
      // Retire withheld for five VALID cycles
      for (int i = 0; i < 4; i++)
         add(0,0,0,0,0,0,                  0, 32'h8000_0100, 1, 1, 32'h0020_8193, 0);
      add(0,0,0,0,1,32'h8000_0104,         0, 32'h8000_0100, 1, 1, 32'h0020_8193, 0);
      // gnt delayed four cycles, spurious retire and rvalid in REQ
      add(0,0,0,0,0,0,                     1, 32'h8000_0104, 0, 0, 0, 0);
      add(0,0,0,0,1,32'hDEAD_BEE0,         1, 32'h8000_0104, 0, 0, 0, 0);
      add(0,0,1,32'hBAD0_BAD0,0,0,         1, 32'h8000_0104, 0, 0, 0, 0);
      add(0,0,0,0,0,0,                     1, 32'h8000_0104, 0, 0, 0, 0);
      add(0,1,0,0,0,0,                     1, 32'h8000_0104, 0, 0, 0, 0);
      // rvalid delayed three WAIT cycles, spurious retire in WAIT
      add(0,0,0,0,0,0,                     0, 32'h8000_0104, 0, 0, 0, 0);
      add(0,0,0,0,1,32'h1234_5678,         0, 32'h8000_0104, 0, 0, 0, 0);
      add(0,0,0,0,0,0,                     0, 32'h8000_0104, 0, 0, 0, 0);
      add(0,0,1,32'h0030_0213,0,0,         0, 32'h8000_0104, 0, 0, 0, 0);
      add(0,0,0,0,0,0,                     0, 32'h8000_0104, 1, 1, 32'h0030_0213, 0);
      add(0,0,0,0,0,0,                     0, 32'h8000_0104, 1, 1, 32'h0030_0213, 0);
      // Misaligned redirect, then ERR is sticky for 20 cycles under busy inputs
      add(0,0,0,0,1,32'h8000_0102,         0, 32'h8000_0104, 1, 1, 32'h0030_0213, 0);
      for (int i = 0; i < 20; i++)
         add(0,1,1,32'hFFFF_0000,1,32'h8000_0200, 0, 32'h8000_0102, 0, 0, 0, 1);
      add(1,0,0,0,0,0,                     0, 32'h8000_0102, 0, 0, 0, 1);
      // Timeout: ERR exactly five cycles after WAIT entry
      add(0,1,0,0,0,0,                     1, A0, 0, 1, NOP, 0);
      for (int i = 0; i < 5; i++)
         add(0,0,0,0,0,0,                  0, A0, 0, 0, 0, 0);
      add(1,0,0,0,0,0,                     0, A0, 0, 0, 0, 1);
      // rvalid on the fourth WAIT cycle
      add(0,1,0,0,0,0,                     1, A0, 0, 1, NOP, 0);
      for (int i = 0; i < 3; i++)
         add(0,0,0,0,0,0,                  0, A0, 0, 0, 0, 0);
      add(0,0,1,32'h0040_0293,0,0,         0, A0, 0, 0, 0, 0);
      add(0,0,0,0,1,32'hFFFF_FFFC,         0, A0, 1, 1, 32'h0040_0293, 0);
      // Top-of-memory PC, rvalid in the cycle the counter reaches TIMEOUT
      add(0,1,0,0,0,0,                     1, 32'hFFFF_FFFC, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++)
         add(0,0,0,0,0,0,                  0, 32'hFFFF_FFFC, 0, 0, 0, 0);
      add(0,0,1,32'h0050_0313,0,0,         0, 32'hFFFF_FFFC, 0, 0, 0, 0);
      add(0,0,0,0,1,32'h8000_0008,         0, 32'hFFFF_FFFC, 1, 1, 32'h0050_0313, 0);
      // Reset mid-WAIT, stale rvalid in the first REQ cycle
      add(0,1,0,0,0,0,                     1, 32'h8000_0008, 0, 0, 0, 0);
      add(1,0,0,0,0,0,                     0, 32'h8000_0008, 0, 0, 0, 0);
      add(0,0,1,32'hDEAD_BEEF,0,0,         1, A0, 0, 1, NOP, 0);
      add(0,1,0,0,0,0,                     1, A0, 0, 1, NOP, 0);
      add(0,0,1,32'h0060_0393,0,0,         0, A0, 0, 0, 0, 0);
      add(0,0,0,0,0,0,                     0, A0, 1, 1, 32'h0060_0393, 0);

      @(posedge clk);
      for (int k = 0; k < vecs.size(); k++) begin
         #1;
         check("imem_req", k, {31'b0, imem_req}, {31'b0, vecs[k].e_req});
         check("instr_valid", k, {31'b0, instr_valid}, {31'b0, vecs[k].e_iv});
         check("fetch_err", k, {31'b0, fetch_err}, {31'b0, vecs[k].e_err});
         check("pc", k, pc, vecs[k].e_pc);
         if (vecs[k].e_req) check("imem_addr", k, imem_addr, vecs[k].e_pc);
         if (vecs[k].ci) check("instr", k, instr, vecs[k].e_instr);
         rst         = vecs[k].rst;
         imem_gnt    = vecs[k].gnt;
         imem_rvalid = vecs[k].rv;
         imem_rdata  = vecs[k].rdata;
         retire      = vecs[k].ret;
         next_pc     = vecs[k].npc;
         @(posedge clk);
      end

      // Bounded wait for the timeout error measured from WAIT entry
      #1;
      rst = 1'b1;
      drive_idle();
      @(posedge clk);
      #1;
      rst = 1'b0;
      imem_gnt = 1'b1;
      @(posedge clk);
      #1;
      imem_gnt = 1'b0;
      n = 0;
      while (!fetch_err && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("timeout_cycles", n, n, 32'd5);
      check("timeout_pc", n, pc, A0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch unit for the RV32I core. It owns the architectural PC and fetches one instruction at a time from instruction memory over a req/gnt/rvalid handshake. It presents the instruction and its PC to decode/execute, and loads the next PC that execute computes when the current instruction retires. It sits upstream of decode and closes the loop on execute's next-PC output.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset; must be word-aligned
- TIMEOUT, 8'd255, maximum WAIT cycles before a fetch error; range 1..255

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address; equals pc whenever imem_req=1
- imem_gnt  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction word
- pc  out  32  PC of the current/in-flight instruction
- instr  out  32  fetched instruction; valid only while instr_valid=1
- instr_valid  out  1  instr/pc stable and consumable by decode/execute
- retire  in  1  execute done with current instruction; sampled only while instr_valid=1
- next_pc  in  32  PC of next instruction; sampled with retire
- fetch_err  out  1  sticky fault: misaligned next_pc or memory timeout

## Operation
- FSM states: REQ, WAIT, VALID, ERR. Reset state is REQ.
- REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_gnt=1, clear the timeout counter and go to WAIT.
  - Otherwise stay in REQ with the address held stable.
  - imem_rvalid is ignored in REQ.
- WAIT:
  - imem_req=0.
  - On imem_rvalid=1, capture imem_rdata into instr and go to VALID.
  - Otherwise increment the 8-bit counter. When the counter equals TIMEOUT with no rvalid, go to ERR.
- VALID:
  - instr_valid=1; instr and pc are held constant.
  - On retire=1, pc <= next_pc.
  - If next_pc[1:0]!=2'b00, go to ERR. Otherwise go to REQ.
  - Without retire, stay indefinitely.
- ERR:
  - fetch_err=1; imem_req=0, instr_valid=0.
  - pc holds the faulting value: the misaligned next_pc, or the address that timed out.
  - Only rst leaves ERR.
- retire is ignored in REQ, WAIT and ERR; pc does not change.
- imem_rdata is captured only on WAIT & imem_rvalid. Any rvalid arriving in other states is dropped.
- Exactly one outstanding request at a time; no prefetch, no speculation.
- instr register contents are don't-care outside VALID. Reset clears instr to 32'h0000_0013 (NOP).

## Timing
- Reset values while rst=1 and in the first cycle after:
  - pc=RESET_PC, imem_addr=RESET_PC
  - instr=32'h0000_0013
  - instr_valid=0, fetch_err=0
  - state=REQ, so imem_req=1 in the first cycle after rst deasserts
- All outputs are decoded from registered state (Moore); no input-to-output combinational path.
- Minimum fetch latency:
  - cycle t: REQ with gnt=1
  - cycle t+1: WAIT with rvalid=1
  - cycle t+2: instr_valid=1
- retire in cycle n (in VALID):
  - n+1: imem_req=1 with imem_addr=next_pc, instr_valid=0
  - n+1: fetch_err=1 instead if next_pc is misaligned
- Timeout: WAIT entered at cycle w with no rvalid → ERR (fetch_err=1) at cycle w+TIMEOUT+1.
- rvalid in the same cycle the counter reaches TIMEOUT: rvalid wins; go to VALID.
- rst asserted in any state, including mid-WAIT: next cycle matches the reset values above. A late rvalid for the aborted request, arriving in REQ, is ignored.
- next_pc wrap: 32'hFFFF_FFFC is legal. pc is 32-bit with no overflow handling.

## Test plan
- Reset/boot: hold rst 3 cycles, memory returns gnt in the same cycle and rvalid 1 cycle later with 32'h0010_0093.
  - First post-reset cycle: imem_req=1, addr=32'h8000_0000.
  - 2 cycles later: instr_valid=1, instr=32'h0010_0093, pc=32'h8000_0000.
- Sequential + branch: retire with next_pc=32'h8000_0004, then retire with next_pc=32'h8000_0100.
  - imem_addr sequence: 8000_0000, 8000_0004, 8000_0100.
  - instr_valid drops for ≥2 cycles between instructions.
- Backpressure: gnt delayed 4 cycles, rvalid delayed 3 cycles, retire withheld 5 cycles in VALID.
  - imem_addr stable throughout REQ.
  - instr/pc constant during VALID.
  - Exactly one request per instruction.
- Misaligned redirect: retire with next_pc=32'h8000_0102.
  - Next cycle: fetch_err=1, pc=32'h8000_0102, imem_req=0.
  - Stays in ERR for 20 cycles until rst.
- Timeout: TIMEOUT=4, gnt given, rvalid never arrives.
  - fetch_err=1 exactly 5 cycles after WAIT entry.
  - Repeat with rvalid arriving on the 4th WAIT cycle: VALID reached, no error.
- Reset mid-fetch and spurious inputs:
  - rst in WAIT, then stale rvalid in the first REQ cycle: ignored, addr=RESET_PC.
  - retire pulses in REQ/WAIT: pc unchanged.
